risc_pipeline_core: RTL and testbench

32-bit, 5-stage pipelined RISC core (IF, ID, EX, MEM, WB) with a 16 x 32-bit register file.
Program memory and data memory are external, combinational-read blocks. The core drives their addresses and reads their data on ports.
Top-level CPU block of the processor, alongside the program-memory and data-memory modules.

---
 rtl/risc_pipeline_core.sv | 162 ++++++++++++++++
 tb/tb_risc_pipeline_core.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_pipeline_core.sv
// 5-stage RISC core (IF/ID/EX/MEM/WB) with a 16x32 register file. There is no forwarding and no interlock.
// An instruction fetched at edge N writes back at edge N+4. A taken branch resolves in MEM and squashes the three younger slots.
module risc_pipeline_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        NReset,
   output logic [31:0] PCinIF,
   input  logic [31:0] InstruccionIn,
   output logic [31:0] alu_outMEM,
   output logic        MemWriteInMEM,
   output logic [31:0] WriteDataInMEM,
   input  logic [31:0] datoMemOut,
   output logic [31:0] PCoutMEM,
   output logic        PCsrc,
   output logic [31:0] result,
   output logic [3:0]  destinoWrWB,
   output logic        escribir
);
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_LW   = 4'h7;
   localparam logic [3:0] OP_SW   = 4'h8;
   localparam logic [3:0] OP_BEQ  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ifId_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [31:0] rs1Val;
      logic [31:0] rs2Val;
      logic [31:0] imm;
      logic [31:0] pc;
   } idEx_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [31:0] aluOut;
      logic [31:0] rs2Val;
      logic [31:0] target;
      logic        equal;
   } exMem_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [31:0] aluOut;
      logic [31:0] memData;
   } memWb_t;

   logic [31:0] pc;
   ifId_t       ifId;
   idEx_t       idEx;
   exMem_t      exMem;
   memWb_t      memWb;
   logic [31:0] regFile [16];

   logic [3:0]  idRs1;
   logic [3:0]  idRs2;
   logic [31:0] idRs1Val;
   logic [31:0] idRs2Val;
   logic [31:0] exAlu;
   logic [31:0] exTarget;
   logic        exEqual;

   assign PCinIF = NReset ? RESET_PC : pc;

   // Register read with write-through from WB; R0 is hardwired to zero even when WB targets it
   assign idRs1 = ifId.instr[23:20];
   assign idRs2 = ifId.instr[19:16];

   always_comb begin
      idRs1Val = regFile[idRs1];
      idRs2Val = regFile[idRs2];
      if (escribir && destinoWrWB == idRs1) idRs1Val = result;
      if (escribir && destinoWrWB == idRs2) idRs2Val = result;
      if (idRs1 == 4'd0) idRs1Val = '0;
      if (idRs2 == 4'd0) idRs2Val = '0;
   end

   always_comb begin
      exAlu = '0;
      case (idEx.op)
         OP_ADD:               exAlu = idEx.rs1Val + idEx.rs2Val;
         OP_SUB:               exAlu = idEx.rs1Val - idEx.rs2Val;
         OP_AND:               exAlu = idEx.rs1Val & idEx.rs2Val;
         OP_OR:                exAlu = idEx.rs1Val | idEx.rs2Val;
         OP_XOR:               exAlu = idEx.rs1Val ^ idEx.rs2Val;
         OP_ADDI, OP_LW, OP_SW: exAlu = idEx.rs1Val + idEx.imm;
         default:              exAlu = '0;
      endcase
   end

   assign exTarget = idEx.pc + 32'd4 + {idEx.imm[29:0], 2'b00};
   assign exEqual  = (idEx.rs1Val == idEx.rs2Val);

   assign alu_outMEM     = exMem.aluOut;
   assign WriteDataInMEM = exMem.rs2Val;
   assign PCoutMEM       = exMem.target;
   // A store sitting in MEM while reset is held must never reach memory
   assign MemWriteInMEM  = !NReset && (exMem.op == OP_SW);
   assign PCsrc          = ((exMem.op == OP_BEQ) && exMem.equal) || (exMem.op == OP_JMP);

   assign result      = (memWb.op == OP_LW) ? memWb.memData : memWb.aluOut;
   assign destinoWrWB = memWb.rd;
   assign escribir    = (memWb.op != OP_NOP) && !memWb.op[3];

   always_ff @(posedge clk) begin
      if (NReset) begin
         pc    <= RESET_PC;
         ifId  <= '0;
         idEx  <= '0;
         exMem <= '0;
         memWb <= '0;
      end else begin
         pc            <= PCsrc ? PCoutMEM : pc + 32'd4;
         memWb.op      <= exMem.op;
         memWb.rd      <= exMem.rd;
         memWb.aluOut  <= exMem.aluOut;
         memWb.memData <= datoMemOut;
         if (PCsrc) begin
            ifId  <= '0;
            idEx  <= '0;
            exMem <= '0;
         end else begin
            ifId.instr   <= InstruccionIn;
            ifId.pc      <= pc;
            idEx.op      <= ifId.instr[31:28];
            idEx.rd      <= ifId.instr[27:24];
            idEx.rs1Val  <= idRs1Val;
            idEx.rs2Val  <= idRs2Val;
            idEx.imm     <= {{16{ifId.instr[15]}}, ifId.instr[15:0]};
            idEx.pc      <= ifId.pc;
            exMem.op     <= idEx.op;
            exMem.rd     <= idEx.rd;
            exMem.aluOut <= exAlu;
            exMem.rs2Val <= idEx.rs2Val;
            exMem.target <= exTarget;
            exMem.equal  <= exEqual;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (NReset) begin
         for (int i = 0; i < 16; i++) regFile[i] <= '0;
      end else if (escribir && destinoWrWB != 4'd0) begin
         regFile[destinoWrWB] <= result;
      end
   end
endmodule

// File: tb/tb_risc_pipeline_core.sv
// Bench for risc_pipeline_core: directed pipeline-timing steps plus random padded programs.
// Every write-back and store is scored against an instruction-level interpreter.
module tb_risc_pipeline_core;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        NReset;
   logic [31:0] PCinIF;
   logic [31:0] InstruccionIn;
   logic [31:0] alu_outMEM;
   logic        MemWriteInMEM;
   logic [31:0] WriteDataInMEM;
   logic [31:0] datoMemOut;
   logic [31:0] PCoutMEM;
   logic        PCsrc;
   logic [31:0] result;
   logic [3:0]  destinoWrWB;
   logic        escribir;

   logic [31:0] imem   [256];
   logic [31:0] dmem   [64];
   logic [31:0] mdlMem [64];

   typedef struct packed {
      logic [3:0]  rd;
      logic [31:0] val;
   } wbEvt_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } stEvt_t;

   wbEvt_t expWb [$];
   stEvt_t expSt [$];

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int cyc        = 0;
   bit monOn      = 0;

   risc_pipeline_core #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .NReset        (NReset),
      .PCinIF        (PCinIF),
      .InstruccionIn (InstruccionIn),
      .alu_outMEM    (alu_outMEM),
      .MemWriteInMEM (MemWriteInMEM),
      .WriteDataInMEM(WriteDataInMEM),
      .datoMemOut    (datoMemOut),
      .PCoutMEM      (PCoutMEM),
      .PCsrc         (PCsrc),
      .result        (result),
      .destinoWrWB   (destinoWrWB),
      .escribir      (escribir)
   );

   assign InstruccionIn = imem[PCinIF[9:2]];
   assign datoMemOut    = dmem[alu_outMEM[7:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) begin
         passCount++;
      end else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: memory write lands on the edge, outputs are sampled on the falling edge
   task automatic tick();
      logic        wr;
      logic [31:0] wa;
      logic [31:0] wd;
      wbEvt_t      we;
      stEvt_t      se;
      #1;
      wr = MemWriteInMEM;
      wa = alu_outMEM;
      wd = WriteDataInMEM;
      @(posedge clk);
      if (wr === 1'b1) dmem[wa[7:2]] = wd;
      @(negedge clk);
      cyc++;
      if (monOn) begin
         if (escribir === 1'b1) begin
            if (expWb.size() == 0) begin
               chk("wbUnexpected", 32'(expWb.size()), 32'd1);
            end else begin
               we = expWb.pop_front();
               chk("wbRd", 32'(destinoWrWB), 32'(we.rd));
               chk("wbVal", result, we.val);
            end
         end
         if (MemWriteInMEM === 1'b1) begin
            if (expSt.size() == 0) begin
               chk("stUnexpected", 32'(expSt.size()), 32'd1);
            end else begin
               se = expSt.pop_front();
               chk("stAddr", alu_outMEM, se.addr);
               chk("stData", WriteDataInMEM, se.data);
            end
         end
      end
   endtask

   task automatic runTo(input int n);
      while (cyc < n) tick();
   endtask

   // Instruction-at-a-time interpreter of the ISA; stops at a jump to itself
   task automatic modelRun();
      logic [31:0] r [16];
      logic [31:0] pcM, ins, a, b, sx, tgt, ea, nxt;
      logic [3:0]  op, rd;
      wbEvt_t      w;
      stEvt_t      s;
      expWb.delete();
      expSt.delete();
      for (int i = 0; i < 16; i++) r[i] = '0;
      for (int i = 0; i < 64; i++) mdlMem[i] = dmem[i];
      pcM = RESET_PC;
      for (int step = 0; step < 4000; step++) begin
         ins = imem[pcM[9:2]];
         op  = ins[31:28];
         rd  = ins[27:24];
         a   = r[ins[23:20]];
         b   = r[ins[19:16]];
         sx  = {{16{ins[15]}}, ins[15:0]};
         tgt = pcM + 32'd4 + (sx << 2);
         ea  = a + sx;
         nxt = pcM + 32'd4;
         if (op == 4'hA && tgt == pcM) break;
         w.rd = rd;
         w.val = '0;
         case (op)
            4'h1: w.val = a + b;
            4'h2: w.val = a - b;
            4'h3: w.val = a & b;
            4'h4: w.val = a | b;
            4'h5: w.val = a ^ b;
            4'h6: w.val = ea;
            4'h7: w.val = mdlMem[ea[7:2]];
            4'h8: begin
               s.addr = ea;
               s.data = b;
               expSt.push_back(s);
               mdlMem[ea[7:2]] = b;
            end
            4'h9: if (a == b) nxt = tgt;
            4'hA: nxt = tgt;
            default: ;
         endcase
         if (op >= 4'h1 && op <= 4'h7) begin
            expWb.push_back(w);
            if (rd != 4'd0) r[rd] = w.val;
         end
         pcM = nxt;
      end
   endtask

   task automatic startProgram(input bit useModel);
      monOn  = 0;
      NReset = 1'b1;
      tick();
      tick();
      NReset = 1'b0;
      #1;
      cyc = 0;
      expWb.delete();
      expSt.delete();
      if (useModel) begin
         modelRun();
         monOn = 1;
      end
   endtask

   task automatic drain();
      int n;
      int mism;
      n = 0;
      while ((expWb.size() != 0 || expSt.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      chk("drainQueues", 32'(expWb.size() + expSt.size()), 32'd0);
      repeat (8) tick();
      mism = 0;
      for (int i = 0; i < 64; i++) if (dmem[i] !== mdlMem[i]) mism++;
      chk("dmemImage", 32'(mism), 32'd0);
   endtask

   // Each instruction is followed by 2 no-op slots (3 after a branch), so results
   // are consumed exactly at the write-through distance and branch squashes only hit padding.
   task automatic genRandom(input int groups);
      logic [3:0]  ops   [64];
      int          start [65];
      int          a, jj, off, v;
      logic [3:0]  rd, rs1, rs2;
      logic [15:0] imm;
      for (int i = 0; i < 256; i++) begin
         v = $urandom_range(0, 5);
         imem[i] = {(v == 0) ? 4'h0 : 4'hA + 4'(v), 28'($urandom)};
      end
      a = 0;
      for (int g = 0; g < groups; g++) begin
         ops[g]   = 4'($urandom_range(0, 15));
         start[g] = a;
         a += (ops[g] == 4'h9 || ops[g] == 4'hA) ? 4 : 3;
      end
      start[groups] = a;
      imem[a] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'hFFFF);
      for (int g = 0; g < groups; g++) begin
         rd  = 4'($urandom);
         rs1 = 4'($urandom);
         rs2 = 4'($urandom);
         imm = 16'($urandom);
         if (ops[g] == 4'h9 || ops[g] == 4'hA) begin
            jj  = $urandom_range(1, (groups - g < 3) ? groups - g : 3);
            off = (start[g + jj] - start[g] - 4) / 4;
            imm = 16'(off);
            if (ops[g] == 4'h9 && $urandom_range(0, 1) == 1) rs2 = rs1;
         end
         imem[start[g]] = enc(ops[g], rd, rs1, rs2, imm);
      end
   endtask

   initial begin
      NReset = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = '0;
      for (int i = 0; i < 64; i++) dmem[i] = $urandom;
      #1;
      chk("pcInReset", PCinIF, RESET_PC);

      // Directed program: arithmetic, store/load, taken branch, R0 immunity
      imem[0]  = enc(4'h6, 4'd1, 4'd0, 4'd0, 16'd5);
      imem[4]  = enc(4'h6, 4'd2, 4'd0, 4'd0, 16'd7);
      imem[8]  = enc(4'h1, 4'd3, 4'd1, 4'd2, 16'd0);
      imem[12] = enc(4'h8, 4'd0, 4'd0, 4'd3, 16'd16);
      imem[13] = enc(4'h7, 4'd4, 4'd0, 4'd0, 16'd16);
      imem[16] = enc(4'h9, 4'd0, 4'd1, 4'd1, 16'd3);
      imem[17] = enc(4'h6, 4'd7, 4'd0, 4'd0, 16'd1);
      imem[18] = enc(4'h8, 4'd0, 4'd0, 4'd1, 16'd20);
      imem[19] = enc(4'h6, 4'd8, 4'd0, 4'd0, 16'd2);
      imem[20] = enc(4'h2, 4'd5, 4'd0, 4'd1, 16'd0);
      imem[21] = enc(4'h6, 4'd0, 4'd0, 4'd0, 16'd9);
      imem[25] = enc(4'h1, 4'd6, 4'd0, 4'd0, 16'd0);
      imem[29] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'hFFFF);
      startProgram(1'b1);

      chk("rstPc", PCinIF, RESET_PC);
      chk("rstResult", result, 32'd0);
      chk("rstAluMem", alu_outMEM, 32'd0);
      chk("rstWrData", WriteDataInMEM, 32'd0);
      chk("rstPcOut", PCoutMEM, 32'd0);
      chk("rstDest", 32'(destinoWrWB), 32'd0);
      chk("rstEscribir", 32'(escribir), 32'd0);
      chk("rstMemWr", 32'(MemWriteInMEM), 32'd0);
      chk("rstPcSrc", 32'(PCsrc), 32'd0);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("seqPc", PCinIF, 32'(4 * k));
         chk("earlyEscribir", 32'(escribir), 32'd0);
         chk("earlyMemWr", 32'(MemWriteInMEM), 32'd0);
      end
      runTo(11);
      chk("addNotYet", 32'(escribir), 32'd0);
      tick();
      chk("addEscribir", 32'(escribir), 32'd1);
      chk("addDest", 32'(destinoWrWB), 32'd3);
      chk("addResult", result, 32'd12);
      runTo(15);
      chk("swAddr", alu_outMEM, 32'd16);
      chk("swData", WriteDataInMEM, 32'd12);
      chk("swMemWr", 32'(MemWriteInMEM), 32'd1);
      runTo(17);
      chk("lwDest", 32'(destinoWrWB), 32'd4);
      chk("lwResult", result, 32'd12);
      runTo(18);
      chk("beqInEx", 32'(PCsrc), 32'd0);
      tick();
      chk("beqPcSrc", 32'(PCsrc), 32'd1);
      chk("beqTarget", PCoutMEM, 32'h50);
      chk("beqPcBefore", PCinIF, 32'h4C);
      tick();
      chk("beqPcAfter", PCinIF, 32'h50);
      chk("beqPcSrcDrop", 32'(PCsrc), 32'd0);
      for (int k = 20; k < 24; k++) begin
         runTo(k);
         chk("flushEscribir", 32'(escribir), 32'd0);
         chk("flushMemWr", 32'(MemWriteInMEM), 32'd0);
      end
      runTo(24);
      chk("subDest", 32'(destinoWrWB), 32'd5);
      chk("subResult", result, 32'hFFFF_FFFB);
      runTo(29);
      chk("r0Dest", 32'(destinoWrWB), 32'd6);
      chk("r0Result", result, 32'd0);
      drain();

      // Reset while a store sits in EX
      for (int i = 0; i < 256; i++) imem[i] = '0;
      dmem[8]  = 32'hCAFE_F00D;
      imem[0]  = enc(4'h6, 4'd1, 4'd0, 4'd0, 16'h0055);
      imem[4]  = enc(4'h8, 4'd0, 4'd0, 4'd1, 16'd32);
      imem[8]  = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'hFFFF);
      startProgram(1'b0);
      runTo(4);
      chk("preRstDest", 32'(destinoWrWB), 32'd1);
      chk("preRstResult", result, 32'h55);
      runTo(6);
      chk("preRstMemWr", 32'(MemWriteInMEM), 32'd0);
      NReset = 1'b1;
      #1;
      chk("midRstPc", PCinIF, RESET_PC);
      tick();
      chk("postRstMemWr", 32'(MemWriteInMEM), 32'd0);
      chk("postRstPc", PCinIF, RESET_PC);
      for (int i = 0; i < 256; i++) imem[i] = '0;
      imem[0] = enc(4'h1, 4'd9, 4'd1, 4'd0, 16'd0);
      imem[4] = enc(4'h8, 4'd0, 4'd0, 4'd1, 16'd40);
      imem[8] = enc(4'h6, 4'd10, 4'd0, 4'd0, 16'h8000);
      imem[12] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'hFFFF);
      NReset = 1'b0;
      #1;
      cyc = 0;
      modelRun();
      monOn = 1;
      runTo(4);
      chk("clearedDest", 32'(destinoWrWB), 32'd9);
      chk("clearedResult", result, 32'd0);
      drain();
      chk("noAbortedStore", dmem[8], 32'hCAFE_F00D);

      // Random padded programs
      for (int p = 0; p < 4; p++) begin
         genRandom(40);
         for (int i = 0; i < 64; i++) dmem[i] = $urandom;
         startProgram(1'b1);
         drain();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
